// File: rtl/regfile_wb_arb.sv
// Two-port register-file writeback arbiter: port A (single-cycle) is unbuffered,
// port B (long-latency) goes through a 2-entry in-order FIFO with a starvation guard.
module regfile_wb_arb #(
  parameter int N_BITS   = 32,
  parameter int N_REGS   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [$clog2(N_REGS)-1:0] a_idx,
  input  logic [N_BITS-1:0]         a_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [$clog2(N_REGS)-1:0] b_idx,
  input  logic [N_BITS-1:0]         b_data,
  output logic                      wr_en,
  output logic [$clog2(N_REGS)-1:0] wr_idx,
  output logic [N_BITS-1:0]         wr_data,
  output logic [1:0]                b_count
);

  localparam int N_IDX = $clog2(N_REGS);
  localparam int SW    = $clog2(MAX_WAIT + 1);

  logic [N_IDX-1:0]  fifo_idx_q  [2];
  logic [N_IDX-1:0]  fifo_idx_d  [2];
  logic [N_BITS-1:0] fifo_data_q [2];
  logic [N_BITS-1:0] fifo_data_d [2];
  logic [1:0]        count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              wr_en_q, wr_en_d;
  logic [N_IDX-1:0]  wr_idx_q, wr_idx_d;
  logic [N_BITS-1:0] wr_data_q, wr_data_d;

  logic b_force, win_a, win_b, push, pop;

  always_comb begin
    b_force = (count_q != 2'd0) && (starve_q == SW'(MAX_WAIT));
    win_a   = a_valid && !b_force;
    win_b   = b_force || (!a_valid && (count_q != 2'd0));
    push    = b_valid && (count_q < 2'd2);
    pop     = win_b;

    fifo_idx_d  = fifo_idx_q;
    fifo_data_d = fifo_data_q;
    count_d     = count_q;
    if (pop) begin
      fifo_idx_d[0]  = fifo_idx_q[1];
      fifo_data_d[0] = fifo_data_q[1];
    end
    // After an optional pop the new entry lands in the first free slot.
    if (push) begin
      if ((count_q == 2'd0) || (pop && (count_q == 2'd1))) begin
        fifo_idx_d[0]  = b_idx;
        fifo_data_d[0] = b_data;
      end else begin
        fifo_idx_d[1]  = b_idx;
        fifo_data_d[1] = b_data;
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    if (pop || (count_q == 2'd0)) begin
      starve_d = '0;
    end else if (win_a && (starve_q != SW'(MAX_WAIT))) begin
      starve_d = starve_q + SW'(1);
    end

    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    if (win_b) begin
      wr_en_d   = (fifo_idx_q[0] != '0);
      wr_idx_d  = fifo_idx_q[0];
      wr_data_d = fifo_data_q[0];
    end else if (win_a) begin
      wr_en_d   = (a_idx != '0);
      wr_idx_d  = a_idx;
      wr_data_d = a_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_idx_q[0]  <= '0;
      fifo_idx_q[1]  <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      count_q        <= 2'd0;
      starve_q       <= '0;
      wr_en_q        <= 1'b0;
      wr_idx_q       <= '0;
      wr_data_q      <= '0;
    end else begin
      fifo_idx_q  <= fifo_idx_d;
      fifo_data_q <= fifo_data_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign a_ready = !b_force;
  assign b_ready = (count_q < 2'd2);
  assign wr_en   = wr_en_q;
  assign wr_idx  = wr_idx_q;
  assign wr_data = wr_data_q;
  assign b_count = count_q;

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Scoreboard bench for regfile_wb_arb: each scenario queues the writes it
// expects in write order; a negedge monitor matches them against wr_en pulses.
module tb_regfile_wb_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_idx, b_idx;
  logic [31:0] a_data, b_data;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic [1:0]  b_count;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;

  regfile_wb_arb #(.N_BITS(32), .N_REGS(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_data(b_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .b_count(b_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_write: got idx=%0d data=%h, required no write", wr_idx, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_idx !== mon_e.idx || wr_data !== mon_e.data) begin
          n_err++;
          $display("FAIL sb_write: got idx=%0d data=%h, required idx=%0d data=%h",
                   wr_idx, wr_data, mon_e.idx, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] idx, input logic [31:0] data);
    wr_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_idx = 5'd3; a_data = 32'hAAAA0003; b_idx = 5'd4; b_data = 32'hBBBB0004;
    repeat (3) step();
    n_cmp++; if (wr_en !== 1'b0)      begin n_err++; $display("FAIL rst_wr_en: got %b, required 0", wr_en); end
    n_cmp++; if (wr_idx !== 5'd0)     begin n_err++; $display("FAIL rst_wr_idx: got %0d, required 0", wr_idx); end
    n_cmp++; if (wr_data !== 32'd0)   begin n_err++; $display("FAIL rst_wr_data: got %h, required 0", wr_data); end
    n_cmp++; if (b_count !== 2'd0)    begin n_err++; $display("FAIL rst_b_count: got %0d, required 0", b_count); end
    n_cmp++; if (a_ready !== 1'b1)    begin n_err++; $display("FAIL rst_a_ready: got %b, required 1", a_ready); end
    n_cmp++; if (b_ready !== 1'b1)    begin n_err++; $display("FAIL rst_b_ready: got %b, required 1", b_ready); end
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    step();
    n_cmp++; if (wr_en !== 1'b0 || b_count !== 2'd0) begin
      n_err++; $display("FAIL rst_release: got wr_en=%b b_count=%0d, required 0/0", wr_en, b_count);
    end
  endtask

  task automatic test_a_only();
    a_valid = 1'b1; a_idx = 5'd5; a_data = 32'hDEADBEEF;
    push_exp(5'd5, 32'hDEADBEEF);
    step();
    a_valid = 1'b0;
    n_cmp++; if (wr_en !== 1'b1 || wr_idx !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL a_only: got en=%b idx=%0d data=%h, required 1/5/deadbeef", wr_en, wr_idx, wr_data);
    end
    step();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL a_only_drop: got wr_en=%b, required 0", wr_en); end
  endtask

  task automatic test_b_only();
    b_valid = 1'b1; b_idx = 5'd7; b_data = 32'h11;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL b_only_ready: got %b, required 1", b_ready); end
    push_exp(5'd7, 32'h11);
    step();
    b_valid = 1'b0;
    n_cmp++; if (b_count !== 2'd1 || wr_en !== 1'b0) begin
      n_err++; $display("FAIL b_only_edge0: got count=%0d en=%b, required 1/0", b_count, wr_en);
    end
    step();
    n_cmp++; if (wr_en !== 1'b1 || wr_idx !== 5'd7 || wr_data !== 32'h11 || b_count !== 2'd0) begin
      n_err++; $display("FAIL b_only_edge1: got en=%b idx=%0d data=%h count=%0d, required 1/7/11/0",
                        wr_en, wr_idx, wr_data, b_count);
    end
    step();
  endtask

  task automatic test_x0();
    a_valid = 1'b1; a_idx = 5'd0; a_data = 32'hCAFE0001;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b, required 1", a_ready); end
    step();
    a_valid = 1'b0;
    n_cmp++; if (wr_en !== 1'b0 || wr_idx !== 5'd0 || wr_data !== 32'hCAFE0001) begin
      n_err++; $display("FAIL x0_drop: got en=%b idx=%0d data=%h, required 0/0/cafe0001", wr_en, wr_idx, wr_data);
    end
    step();
  endtask

  // One B entry against continuous A traffic: A wins 4 times, then B is forced.
  task automatic test_starvation();
    for (int i = 0; i < 7; i++) begin
      a_valid = 1'b1; a_idx = 5'(10 + i); a_data = 32'h100 + i;
      b_valid = (i == 0); b_idx = 5'd9; b_data = 32'h99;
      n_cmp++; if (a_ready !== (i != 5)) begin
        n_err++; $display("FAIL starve_a_ready[%0d]: got %b, required %b", i, a_ready, (i != 5));
      end
      if (i == 5) push_exp(5'd9, 32'h99);
      else        push_exp(5'(10 + i), 32'h100 + i);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    n_cmp++; if (b_count !== 2'd0) begin n_err++; $display("FAIL starve_drain: got count=%0d, required 0", b_count); end
  endtask

  task automatic test_full();
    int  bi;
    logic exp_br;
    bi = 0;
    for (int i = 0; i < 7; i++) begin
      a_valid = 1'b1; a_idx = 5'(1 + i); a_data = 32'h200 + i;
      b_valid = (bi < 3); b_idx = 5'(24 + bi); b_data = 32'h300 + bi;
      exp_br = !(i >= 2 && i <= 5);
      n_cmp++; if (b_ready !== exp_br) begin
        n_err++; $display("FAIL full_b_ready[%0d]: got %b, required %b", i, b_ready, exp_br);
      end
      if (i == 2) begin
        n_cmp++; if (b_count !== 2'd2) begin n_err++; $display("FAIL full_count: got %0d, required 2", b_count); end
      end
      if (i == 5) push_exp(5'd24, 32'h300);
      else        push_exp(5'(1 + i), 32'h200 + i);
      if (b_valid && exp_br) bi++;
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    n_cmp++; if (bi != 3) begin n_err++; $display("FAIL full_accepts: got %0d, required 3", bi); end
    push_exp(5'd25, 32'h301);
    push_exp(5'd26, 32'h302);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    n_cmp++; if (exp_q.size() != 0) begin
      n_err++; $display("FAIL full_drain_timeout: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_idx = 5'd3; a_data = 32'h400 + i;
      b_valid = (i < 2); b_idx = 5'd30; b_data = 32'h500 + i;
      push_exp(5'd3, 32'h400 + i);
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    n_cmp++; if (b_count !== 2'd2) begin n_err++; $display("FAIL mid_pre_count: got %0d, required 2", b_count); end
    #5;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (wr_en !== 1'b0 || b_count !== 2'd0) begin
      n_err++; $display("FAIL mid_async: got en=%b count=%0d, required 0/0", wr_en, b_count);
    end
    #1;
    rst_n = 1'b1;
    step();
    repeat (8) step();
    n_cmp++; if (b_count !== 2'd0 || exp_q.size() != 0) begin
      n_err++; $display("FAIL mid_after: got count=%0d pending=%0d, required 0/0", b_count, exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_idx = '0; a_data = '0; b_idx = '0; b_data = '0;
    test_reset();
    test_a_only();
    test_b_only();
    test_x0();
    test_starvation();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001: Parameter N_BITS, default 32, data width of each writeback result.
REQ-002: Parameter N_REGS, default 32, number of architectural registers; N_IDX = $clog2(N_REGS) is a localparam.
REQ-003: Parameter MAX_WAIT, default 4, number of consecutive cycles port B's head may lose before it wins by force.
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: rst_n  input  1  reset, asynchronous and active-low.
REQ-006: a_valid  input  1  single-cycle (ALU) result valid.
REQ-007: a_ready  output  1  port A accept, combinational.
REQ-008: a_idx  input  N_IDX  port A destination register.
REQ-009: a_data  input  N_BITS  port A result.
REQ-010: b_valid  input  1  long-latency (load/muldiv) result valid.
REQ-011: b_ready  output  1  port B accept.
REQ-012: b_idx  input  N_IDX  port B destination register.
REQ-013: b_data  input  N_BITS  port B result.
REQ-014: wr_en  output  1  regfile write enable, registered.
REQ-015: wr_idx  output  N_IDX  regfile write index, registered.
REQ-016: wr_data  output  N_BITS  regfile write data, registered.
REQ-017: b_count  output  2  current port-B FIFO occupancy (0..2).

Function
REQ-018: A handshake occurs on a port when valid and ready are both high at a rising edge.
REQ-019: Port B SHALL feed a 2-entry in-order FIFO; b_ready = (b_count < 2), independent of any same-cycle pop.
REQ-020: Port A is unbuffered; the winning A result goes directly to the output register.
REQ-021: b_force = (b_count > 0) && (starve_cnt == MAX_WAIT); a_ready = !b_force.
REQ-022: Winner each cycle: if b_force, FIFO head; else if a_valid, port A; else if b_count > 0, FIFO head; else none.
REQ-023: A FIFO head that wins is popped at that edge.
REQ-024: An entry pushed at edge N is not eligible before the cycle following edge N; there is no bypass from b_* to the output.
REQ-025: starve_cnt resets to 0, clears to 0 on every FIFO pop or whenever b_count == 0, and increments, saturating at MAX_WAIT, when b_count > 0 and port A wins.
REQ-026: On a winner, the edge loads wr_idx and wr_data from the winner, and wr_en <= (winner idx != 0).
REQ-027: A write to x0 is consumed (handshake, pop) but produces wr_en = 0.
REQ-028: With no winner, wr_en <= 0 and wr_idx and wr_data hold their values.
REQ-029: Latency is 1 cycle from A handshake to wr_en, and at least 2 cycles from B handshake to wr_en.
REQ-030: Simultaneous push and pop at b_count == 1 leaves b_count == 1 with order preserved; at b_count == 2 a pop frees a slot only for the next cycle.
REQ-031: Port-B results SHALL be written in acceptance order; ordering between A and B is arbitration order only.

Reset
REQ-032: On rst_n low, asynchronously set wr_en = 0, wr_idx = 0, wr_data = 0, b_count = 0 and starve_cnt = 0, and drop FIFO contents.
REQ-033: During reset a_ready = 1 and b_ready = 1, but no handshake SHALL be recorded while rst_n is low.
REQ-034: Reset asserted mid-operation discards all buffered B results without any write; the first edge after release behaves as from idle.

Verification
REQ-035: A only: a_valid = 1, a_idx = 5, a_data = 0xDEADBEEF for one cycle -> next cycle wr_en = 1, wr_idx = 5, wr_data = 0xDEADBEEF; the following cycle wr_en = 0.
REQ-036: B only: b_idx = 7, b_data = 0x11 at edge 0 -> b_count = 1 at edge 0, wr_en = 1 with wr_idx = 7 after edge 1, and b_count = 0.
REQ-037: x0 drop: a_idx = 0, a_valid = 1 -> a_ready = 1 and wr_en stays 0; wr_idx and wr_data update to 0 and a_data.
REQ-038: Starvation: a_valid held 1, one B entry queued, MAX_WAIT = 4 -> A wins 4 cycles, then a_ready = 0 for exactly 1 cycle, B is written, and A resumes.
REQ-039: Full: three back-to-back B pushes while a_valid = 1 -> b_ready = 0 after the 2nd push, the 3rd accepted only after the first pop, and write order matches push order.
REQ-040: Reset mid-operation: b_count = 2, rst_n pulsed low between edges -> wr_en = 0 and b_count = 0 immediately, and no B write ever appears.
